iq: RTL and testbench

Instruction queue between the decode/rename stage and the issue stage. It buffers up to `DEPTH` decoded entries (`iq_entry_t`: `dec_inst` plus `rob_slot`) in program order. Each cycle it presents the four oldest entries to issue and retires the in-order prefix that issue reports as consumed. It accepts up to four new entries per cycle from decode and is cleared on a pipeline flush.

---
 rtl/iq.sv | 84 ++++++++
 tb/tb_iq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/iq.sv
// Instruction queue between decode/rename and issue: in-order circular buffer
// accepting up to four entries per cycle and retiring an in-order prefix of up to four.
module iq #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned DEC_W = 32,
    parameter int unsigned ROB_W = 6,
    localparam int unsigned ENTRY_W = DEC_W + ROB_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic [3:0]         in_valid,
    input  logic [ENTRY_W-1:0] in_entry [4],
    output logic               in_ready,
    input  logic               ext_enable,
    input  logic [1:0]         ext_consumed,
    output logic [3:0]         ext_valid,
    output logic [ENTRY_W-1:0] insns [4],
    output logic               empty,
    output logic [PTR_W:0]     count_o
);

    // Entry layout: {dec_inst, rob_slot}, rob_slot in the low ROB_W bits.
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     count;

    logic [3:0] lane_ok;
    logic [2:0] n_acc;
    logic [2:0] n_req;
    logic [2:0] n_out;

    assign in_ready = (count <= (PTR_W+1)'(DEPTH - 4));
    assign empty    = (count == '0);
    assign count_o  = count;

    // Only the contiguous prefix of valid lanes counts, and only while ready.
    assign lane_ok = {&in_valid[3:0], &in_valid[2:0], &in_valid[1:0], in_valid[0]}
                     & {4{in_ready}};

    always_comb begin
        n_acc = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            n_acc = n_acc + 3'(lane_ok[i]);
        end
        n_req = ext_enable ? (3'(ext_consumed) + 3'd1) : 3'd0;
        // Clamp to occupancy; count is below 4 whenever the clamp applies.
        n_out = ((PTR_W+1)'(n_req) > count) ? count[2:0] : n_req;
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            ext_valid[i] = (count > (PTR_W+1)'(i));
            insns[i]     = mem[head + PTR_W'(i)];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (lane_ok[k]) begin
                    mem[tail + PTR_W'(k)] <= in_entry[k];
                end
            end
            head  <= head + PTR_W'(n_out);
            tail  <= tail + PTR_W'(n_acc);
            count <= count + (PTR_W+1)'(n_acc) - (PTR_W+1)'(n_out);
        end
    end

endmodule

// File: tb/tb_iq.sv
// Self-checking bench for iq: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_iq;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam int DEC_W = 32;
    localparam int ROB_W = 6;
    localparam int EW    = DEC_W + ROB_W;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic [3:0]    in_valid;
    logic [EW-1:0] in_entry [4];
    logic          in_ready;
    logic          ext_enable;
    logic [1:0]    ext_consumed;
    logic [3:0]    ext_valid;
    logic [EW-1:0] insns [4];
    logic          empty;
    logic [PTR_W:0] count_o;

    always #5 clock = ~clock;

    iq #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DEC_W(DEC_W), .ROB_W(ROB_W)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_entry(in_entry),
        .in_ready(in_ready),
        .ext_enable(ext_enable),
        .ext_consumed(ext_consumed),
        .ext_valid(ext_valid),
        .insns(insns),
        .empty(empty),
        .count_o(count_o)
    );

    logic [EW-1:0]    q [$];
    logic [ROB_W-1:0] next_slot = '0;
    bit               just_reset = 1'b0;
    int               vectors = 0;
    int               miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic en, input logic [1:0] c,
                         input logic fl, input logic rs);
        in_valid     = v;
        ext_enable   = en;
        ext_consumed = c;
        flush        = fl;
        reset        = rs;
        for (int k = 0; k < 4; k++) begin
            in_entry[k] = {DEC_W'($urandom), ROB_W'(next_slot + ROB_W'(k))};
        end
    endtask

    // Reference: the queue holds exactly the live entries, oldest first.
    task automatic model_update();
        int  sz;
        int  n_req;
        int  n_out;
        bit  rdy;
        bit  run;
        if (reset) begin
            q.delete();
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (flush) begin
                q.delete();
            end else begin
                sz    = q.size();
                rdy   = (DEPTH - sz) >= 4;
                n_req = ext_enable ? int'(ext_consumed) + 1 : 0;
                n_out = (n_req < sz) ? n_req : sz;
                for (int i = 0; i < n_out; i++) void'(q.pop_front());
                run = rdy;
                for (int k = 0; k < 4; k++) begin
                    if (!in_valid[k]) run = 1'b0;
                    if (run) begin
                        q.push_back(in_entry[k]);
                        next_slot = next_slot + 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        int sz;
        sz = q.size();
        vectors++;
        chk("count_o", 64'(count_o), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("in_ready", 64'(in_ready), 64'((DEPTH - sz) >= 4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ext_valid[%0d]", i), 64'(ext_valid[i]), 64'(sz > i));
            if (i < sz) chk($sformatf("insns[%0d]", i), 64'(insns[i]), 64'(q[i]));
            if (just_reset) chk($sformatf("insns_rst[%0d]", i), 64'(insns[i]), 64'(0));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
        compare();
    endtask

    initial begin
        // 1: reset, then four entries with rob_slot 0..3
        drive(4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        chk("lit_rst_count", 64'(count_o), 64'd0);
        chk("lit_rst_empty", 64'(empty), 64'd1);
        chk("lit_rst_ready", 64'(in_ready), 64'd1);
        chk("lit_rst_valid", 64'(ext_valid), 64'h0);
        next_slot = '0;
        drive(4'hf, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk("lit_enq4_count", 64'(count_o), 64'd4);
        chk("lit_enq4_valid", 64'(ext_valid), 64'hf);
        chk("lit_enq4_empty", 64'(empty), 64'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("lit_enq4_slot[%0d]", i), 64'(insns[i][ROB_W-1:0]), 64'(i));

        // 2: dequeue two, then over-consume
        drive(4'b0011, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk("lit_six", 64'(count_o), 64'd6);
        drive(4'h0, 1'b1, 2'd1, 1'b0, 1'b0);
        tick();
        chk("lit_deq2_count", 64'(count_o), 64'd4);
        chk("lit_deq2_slot", 64'(insns[0][ROB_W-1:0]), 64'd2);
        tick();
        chk("lit_deq2b_count", 64'(count_o), 64'd2);
        drive(4'h0, 1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        chk("lit_clamp_count", 64'(count_o), 64'd0);
        chk("lit_clamp_empty", 64'(empty), 64'd1);

        // 3: fill toward full, refused enqueue, then dequeue reopens
        drive(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'hf, 1'b0, 2'd0, 1'b0, 1'b0);
            tick();
        end
        chk("lit_13_count", 64'(count_o), 64'd13);
        chk("lit_13_ready", 64'(in_ready), 64'd0);
        drive(4'hf, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk("lit_refused_count", 64'(count_o), 64'd13);
        drive(4'hf, 1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        chk("lit_reopen_count", 64'(count_o), 64'd9);
        chk("lit_reopen_ready", 64'(in_ready), 64'd1);

        // 4: steady 4-in/4-out at occupancy 8 across pointer wrap
        drive(4'h0, 1'b1, 2'd0, 1'b0, 1'b0);
        tick();
        chk("lit_eight", 64'(count_o), 64'd8);
        for (int i = 0; i < 20; i++) begin
            drive(4'hf, 1'b1, 2'd3, 1'b0, 1'b0);
            tick();
            chk("lit_steady_count", 64'(count_o), 64'd8);
        end

        // 5: non-contiguous lanes, only lane 0 counts
        drive(4'b1101, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk("lit_prefix_count", 64'(count_o), 64'd9);

        // 6: flush with traffic, then reset with flush and traffic
        drive(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk("lit_ten", 64'(count_o), 64'd10);
        drive(4'hf, 1'b1, 2'd1, 1'b1, 1'b0);
        tick();
        chk("lit_flush_count", 64'(count_o), 64'd0);
        chk("lit_flush_empty", 64'(empty), 64'd1);
        chk("lit_flush_valid", 64'(ext_valid), 64'h0);
        drive(4'hf, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        drive(4'hf, 1'b1, 2'd1, 1'b1, 1'b1);
        tick();
        chk("lit_rst2_count", 64'(count_o), 64'd0);
        chk("lit_rst2_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("lit_rst2_insns[%0d]", i), 64'(insns[i]), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 399) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
